// File: rtl/sha256_core_arbiter.sv
// Round-robin arbiter that time-shares one SHA-256 core among requesters.
// Owns the issue/wait/deliver handshake and a watchdog on the core.
module sha256_core_arbiter #(
  parameter int num_req_p  = 4,
  parameter int id_width_p = $clog2(num_req_p),
  parameter int timeout_p  = 255
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [num_req_p-1:0]       req_v_i,
  input  logic [256*num_req_p-1:0]   req_msg_i,
  output logic [num_req_p-1:0]       req_ready_o,
  output logic [num_req_p-1:0]       resp_v_o,
  output logic [255:0]               resp_digest_o,
  input  logic [num_req_p-1:0]       resp_yumi_i,
  output logic                       core_v_o,
  output logic [255:0]               core_msg_o,
  input  logic                       core_ready_i,
  input  logic                       core_v_i,
  input  logic [255:0]               core_digest_i,
  output logic                       core_yumi_o,
  output logic [id_width_p-1:0]      grant_id_o,
  output logic                       busy_o,
  output logic                       error_o
);

  localparam int wd_width_lp = $clog2(timeout_p + 1);
  localparam logic [wd_width_lp-1:0] wd_max_lp = wd_width_lp'(timeout_p);
  localparam logic [id_width_p-1:0] last_rst_lp = id_width_p'(num_req_p - 1);

  typedef enum logic [1:0] {
    eIdle,
    eIssue,
    eWait,
    eDeliver
  } state_e;

  state_e                  state_q, state_d;
  logic [id_width_p-1:0]   last_q, last_d;
  logic [id_width_p-1:0]   grant_q, grant_d;
  logic [255:0]            msg_q, msg_d;
  logic [255:0]            digest_q, digest_d;
  logic [wd_width_lp-1:0]  wd_q, wd_d;
  logic                    error_q, error_d;

  logic                    win_v;
  logic [id_width_p-1:0]   win_id;
  logic [id_width_p-1:0]   rr_idx;
  logic [num_req_p-1:0]    ready_oh;
  logic [num_req_p-1:0]    resp_oh;
  logic                    core_v;
  logic                    core_yumi;

  // Search starts just after the last served requester.
  always_comb begin
    win_v  = 1'b0;
    win_id = '0;
    rr_idx = '0;
    for (int i = 1; i <= num_req_p; i++) begin
      rr_idx = id_width_p'((int'(last_q) + i) % num_req_p);
      if (!win_v && req_v_i[rr_idx]) begin
        win_v  = 1'b1;
        win_id = rr_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    msg_d     = msg_q;
    digest_d  = digest_q;
    wd_d      = wd_q;
    error_d   = error_q;
    ready_oh  = '0;
    resp_oh   = '0;
    core_v    = 1'b0;
    core_yumi = 1'b0;
    unique case (state_q)
      eIdle: begin
        if (win_v) begin
          ready_oh[win_id] = 1'b1;
          msg_d   = req_msg_i[256*win_id +: 256];
          grant_d = win_id;
          state_d = eIssue;
        end
      end
      eIssue: begin
        core_v = 1'b1;
        if (core_ready_i) begin
          wd_d    = '0;
          state_d = eWait;
        end
      end
      eWait: begin
        // A digest arriving on the last watchdog cycle still wins.
        if (core_v_i) begin
          core_yumi = 1'b1;
          digest_d  = core_digest_i;
          state_d   = eDeliver;
        end else if (wd_q == wd_max_lp) begin
          error_d = 1'b1;
          last_d  = grant_q;
          state_d = eIdle;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      eDeliver: begin
        resp_oh[grant_q] = 1'b1;
        if (resp_yumi_i[grant_q]) begin
          last_d  = grant_q;
          state_d = eIdle;
        end
      end
      default: state_d = eIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= eIdle;
      last_q   <= last_rst_lp;
      grant_q  <= '0;
      msg_q    <= '0;
      digest_q <= '0;
      wd_q     <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      msg_q    <= msg_d;
      digest_q <= digest_d;
      wd_q     <= wd_d;
      error_q  <= error_d;
    end
  end

  // Outputs are forced low while reset is held, even before state clears.
  assign req_ready_o   = reset_i ? '0 : ready_oh;
  assign resp_v_o      = reset_i ? '0 : resp_oh;
  assign resp_digest_o = reset_i ? '0 : digest_q;
  assign core_v_o      = core_v & ~reset_i;
  assign core_msg_o    = reset_i ? '0 : msg_q;
  assign core_yumi_o   = core_yumi & ~reset_i;
  assign grant_id_o    = reset_i ? '0 : grant_q;
  assign busy_o        = (state_q != eIdle) & ~reset_i;
  assign error_o       = error_q & ~reset_i;

endmodule

// File: doc/sha256_core_arbiter.md
# sha256_core_arbiter

Round-robin arbiter and sequencer that shares one SHA256_core instance among `num_req_p` requesters. It accepts a 256-bit message from one requester at a time, issues it to the core with a valid/ready handshake, and collects the digest with `yumi`. It returns the digest only to the granted requester. A watchdog flags a core that never answers. It sits between the fsb-side request channels and the core.

## Interface
- `num_req_p`, 4: number of requesters, 2..16.
- `id_width_p`, `$clog2(num_req_p)`: width of the grant index.
- `timeout_p`, 255: maximum cycles in eWait before abort, 1..1023.

Ports:
- `clk_i`  in  1  : the single clock.
- `reset_i`  in  1  : synchronous, active-high reset.
- `req_v_i`  in  num_req_p  : per-requester message valid.
- `req_msg_i`  in  256*num_req_p  : requester k message is at bits [256k+255:256k].
- `req_ready_o`  out  num_req_p  : one-hot accept strobe.
- `resp_v_o`  out  num_req_p  : one-hot digest valid for the granted requester.
- `resp_digest_o`  out  256  : digest, shared by all requesters.
- `resp_yumi_i`  in  num_req_p  : per-requester digest consume.
- `core_v_o`  out  1  : message valid to the core.
- `core_msg_o`  out  256  : message to the core.
- `core_ready_i`  in  1  : core can accept a message.
- `core_v_i`  in  1  : core digest valid.
- `core_digest_i`  in  256  : core digest.
- `core_yumi_o`  out  1  : digest consumed.
- `grant_id_o`  out  id_width_p  : index of the current or last grantee.
- `busy_o`  out  1  : high when the state is not eIdle.
- `error_o`  out  1  : sticky timeout flag.

## Operation

States are eIdle, eIssue, eWait and eDeliver.

eIdle:
- Outputs: `core_v_o` = 0, `resp_v_o` = 0.
- If any `req_v_i` bit is set, choose the winner by round-robin. The search starts at `last_r+1` (mod `num_req_p`) and takes the first set bit.
- In the same cycle, assert `req_ready_o[winner]` = 1; all other bits stay 0.
- Register `msg_r` <= the winner's message and `grant_r` <= winner, then go to eIssue.
- With no request, `req_ready_o` = 0 and the state stays eIdle.

eIssue:
- Drive `core_v_o` = 1 and `core_msg_o` = `msg_r`.
- When `core_ready_i` = 1, the handshake completes: go to eWait and clear `wd_r` to 0.
- `core_v_o` stays high until the handshake; `msg_r` stays stable.

eWait:
- `core_v_o` = 0 and `wd_r` increments each cycle.
- If `core_v_i` = 1: `core_yumi_o` = 1 combinationally in the same cycle, `digest_r` <= `core_digest_i`, go to eDeliver.
- Else if `wd_r` == `timeout_p`: set `error_o` <= 1, `last_r` <= `grant_r`, go to eIdle. No response is produced and the request is dropped.
- If `core_v_i` arrives in the same cycle `wd_r` reaches `timeout_p`, the digest wins and there is no error.

eDeliver:
- `resp_v_o[grant_r]` = 1 and `resp_digest_o` = `digest_r`.
- On `resp_yumi_i[grant_r]` = 1: `last_r` <= `grant_r`, go to eIdle.
- `resp_yumi_i` bits for non-granted requesters are ignored in every state.

Outputs and registers:
- `core_yumi_o` is 0 in every state except eWait when `core_v_i` = 1.
- `grant_id_o` = `grant_r`.
- `busy_o` = (state != eIdle).
- `error_o` is cleared only by reset.
- `wd_r` is `$clog2(timeout_p+1)` bits wide. It saturates and cannot wrap because eWait exits at `timeout_p`.

## Timing

Reset values:
- state = eIdle.
- `last_r` = `num_req_p`-1, so requester 0 has first priority.
- `grant_r` = 0, `msg_r` = 0, `digest_r` = 0, `wd_r` = 0, `error_o` = 0.
- All outputs are 0 during and after reset.

Reset mid-operation:
- Reset in any state returns to eIdle the next cycle.
- A pending digest is dropped and `core_yumi_o` is not asserted.
- Reset the core with the same `reset_i`.

Latency:
- Request accepted at cycle T.
- `core_v_o` is high at T+1.
- Core handshake at T+1 if `core_ready_i` = 1.
- `resp_v_o` rises 1 cycle after `core_v_i`.
- Back-to-back service: the next request can be accepted 1 cycle after the yumi (the eIdle cycle).

Handshake rules:
- `req_ready_o` depends combinationally on `req_v_i` in eIdle only.
- `req_v_i` may drop without acceptance; the arbiter holds no request state before acceptance.
- `resp_v_o` and `resp_digest_o` stay stable until yumi.

Fairness:
- After requester k is served (or aborted), k has lowest priority.
- With all requesters continuously valid, grants rotate 0, 1, ..., N-1, 0, ...

## Test plan
- **Single request:** `req_v_i` = 0001 with msg A. Required response: `req_ready_o` = 0001 at T; `core_v_o` = 1 with `core_msg_o` = A at T+1. The core model returns D after 66 cycles. `core_yumi_o` pulses in that cycle; `resp_v_o` = 0001 with D next cycle; yumi returns the block to idle with `busy_o` = 0.
- **Round-robin:** `req_v_i` = 1111 held, with distinct messages. Required response: grant order 0, 1, 2, 3, 0. Each digest is routed only to its grantee's `resp_v_o` bit.
- **Back-pressure:** `core_ready_i` = 0 for 5 cycles, then 1. Required response: `core_v_o` high and `core_msg_o` constant all 5 cycles. In eDeliver, withhold yumi for 10 cycles and pulse a non-granted `resp_yumi_i` bit. Required response: `resp_v_o` and digest hold; the stray yumi is ignored.
- **Timeout:** `timeout_p` = 8 and the core never asserts `core_v_i`. Required response: `error_o` = 1 exactly when `wd_r` reaches 8, return to eIdle, no `resp_v_o`. The next request (requester 1 pending) is granted normally and `error_o` stays 1.
- **Timeout race:** `core_v_i` arrives in the cycle `wd_r` = `timeout_p`. Required response: the digest is delivered and `error_o` stays 0.
- **Reset mid-operation:** assert reset in eWait and again in eDeliver. Required response: state is eIdle and all outputs are 0 the next cycle. The first grant after reset goes to requester 0.
